// File: rtl/clk_gen_nco.sv
// clk_gen_nco
//   Programmable square-wave generator running from the 50 MHz system clock.
//   A modulo-SYS_HZ phase accumulator adds 2*F each cycle. Each wrap toggles
//   CLK_OUT, so the long-term output frequency is exactly F Hz.
//   Frequency changes made while running are applied only on a CLK_OUT fall,
//   so no high phase is ever cut short.
//
// Ports
//   CLK_50M   in   system clock (single domain)
//   RST_N     in   asynchronous active-low reset
//   GEN_EN    in   1 = run, 0 = stop after the current high phase
//   FREQ_HZ   in   requested frequency in Hz, sampled with FREQ_VLD
//   FREQ_VLD  in   one-cycle load request
//   FREQ_BUSY out  an accepted request is waiting for the next fall
//   FREQ_ACK  out  one-cycle pulse when a new frequency takes effect
//   FREQ_ERR  out  one-cycle pulse when a request is rejected
//   CLK_OUT   out  generated clock (registered)
module clk_gen_nco #(
    parameter int SYS_HZ  = 50000000,
    parameter int FMAX_HZ = 12500000
) (
    input  logic        CLK_50M,
    input  logic        RST_N,
    input  logic        GEN_EN,
    input  logic [31:0] FREQ_HZ,
    input  logic        FREQ_VLD,
    output logic        FREQ_BUSY,
    output logic        FREQ_ACK,
    output logic        FREQ_ERR,
    output logic        CLK_OUT
);

    localparam logic [26:0] SYS_C  = 27'(SYS_HZ);
    localparam logic [31:0] FMAX_C = 32'(FMAX_HZ);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PEND,
        ST_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [25:0] acc_q, acc_d;
    logic [26:0] inc_q, inc_d;
    logic [31:0] freq_cur_q, freq_cur_d;
    logic [31:0] freq_new_q, freq_new_d;
    logic        clk_q, clk_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;

    logic [26:0] sum;
    logic        wrap;
    logic [25:0] acc_step;
    logic        clk_step;
    logic        fall;
    logic        req_ok;

    always_comb begin
        // inc <= SYS_HZ/2 guarantees at most one wrap per cycle
        sum      = {1'b0, acc_q} + inc_q;
        wrap     = (sum >= SYS_C);
        acc_step = wrap ? 26'(sum - SYS_C) : sum[25:0];
        clk_step = clk_q ^ wrap;
        fall     = wrap & clk_q;
        // only one request may be outstanding at a time
        req_ok   = FREQ_VLD && (FREQ_HZ <= FMAX_C) && (state_q != ST_PEND);
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        inc_d      = inc_q;
        freq_cur_d = freq_cur_q;
        freq_new_d = freq_new_q;
        clk_d      = clk_q;
        ack_d      = 1'b0;
        err_d      = FREQ_VLD && !req_ok;

        case (state_q)
            ST_IDLE: begin
                acc_d = '0;
                clk_d = 1'b0;
                if (req_ok) begin
                    freq_cur_d = FREQ_HZ;
                    inc_d      = {FREQ_HZ[25:0], 1'b0};
                    ack_d      = 1'b1;
                end
                if (GEN_EN && freq_cur_q != '0) state_d = ST_RUN;
            end
            ST_RUN: begin
                acc_d = acc_step;
                clk_d = clk_step;
                if (req_ok) begin
                    freq_new_d = FREQ_HZ;
                    state_d    = ST_PEND;
                end else if (!GEN_EN) begin
                    state_d = ST_STOP;
                end
            end
            ST_PEND: begin
                // keep the old rate until the fall, then restart phase at 0
                acc_d = acc_step;
                clk_d = clk_step;
                if (fall) begin
                    freq_cur_d = freq_new_q;
                    inc_d      = {freq_new_q[25:0], 1'b0};
                    acc_d      = '0;
                    ack_d      = 1'b1;
                    state_d    = (freq_new_q == '0 || !GEN_EN) ? ST_IDLE : ST_RUN;
                end
            end
            ST_STOP: begin
                if (req_ok) begin
                    freq_cur_d = FREQ_HZ;
                    inc_d      = {FREQ_HZ[25:0], 1'b0};
                    ack_d      = 1'b1;
                end
                if (GEN_EN && freq_cur_d != '0) begin
                    // resume without touching the phase
                    acc_d   = acc_step;
                    clk_d   = clk_step;
                    state_d = ST_RUN;
                end else if (!clk_q) begin
                    acc_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    // finish the high phase in full before going idle
                    acc_d = acc_step;
                    clk_d = clk_step;
                    if (fall) begin
                        acc_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            inc_q      <= '0;
            freq_cur_q <= '0;
            freq_new_q <= '0;
            clk_q      <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            inc_q      <= inc_d;
            freq_cur_q <= freq_cur_d;
            freq_new_q <= freq_new_d;
            clk_q      <= clk_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign CLK_OUT   = clk_q;
    assign FREQ_BUSY = (state_q == ST_PEND);
    assign FREQ_ACK  = ack_q;
    assign FREQ_ERR  = err_q;

endmodule

// File: tb/tb_clk_gen_nco.sv
// tb_clk_gen_nco
//   Self-checking bench for clk_gen_nco. A reference model gives CLK_OUT after
//   k accumulation cycles from zero phase as the parity of floor(k*2F/SYS_HZ).
//   A table of load requests checks accept/reject and first-rise latency.
//   Hand-written sequences cover stop, glitch-free change, load of zero and
//   asynchronous reset.
module tb_clk_gen_nco;

    localparam longint SYS = 50000000;

    logic        CLK_50M = 1'b0;
    logic        RST_N;
    logic        GEN_EN;
    logic [31:0] FREQ_HZ;
    logic        FREQ_VLD;
    logic        FREQ_BUSY;
    logic        FREQ_ACK;
    logic        FREQ_ERR;
    logic        CLK_OUT;

    int n_tests = 0;
    int n_fail  = 0;

    clk_gen_nco dut (
        .CLK_50M  (CLK_50M),
        .RST_N    (RST_N),
        .GEN_EN   (GEN_EN),
        .FREQ_HZ  (FREQ_HZ),
        .FREQ_VLD (FREQ_VLD),
        .FREQ_BUSY(FREQ_BUSY),
        .FREQ_ACK (FREQ_ACK),
        .FREQ_ERR (FREQ_ERR),
        .CLK_OUT  (CLK_OUT)
    );

    always #10 CLK_50M = ~CLK_50M;

    typedef struct {
        longint freq;
        bit     exp_err;
        bit     exp_ack;
        int     exp_rise;   // 0 = no rise expected
    } vec_t;

    vec_t tbl[9];

    function automatic logic mclk(input longint f, input longint k);
        longint t;
        t = (k * 2 * f) / SYS;
        return t[0];
    endfunction

    task automatic step();
        @(posedge CLK_50M);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Load f in IDLE, run ncyc cycles against the model, then disable and
    // check the high phase completes before the output parks low.
    task automatic run_check(input longint f, input int ncyc);
        longint k;
        logic   e;
        bit     stopped;
        int     budget;
        FREQ_HZ = f[31:0]; FREQ_VLD = 1'b1;
        step();
        FREQ_VLD = 1'b0;
        chk("load_ack", FREQ_ACK, 1);
        chk("load_err", FREQ_ERR, 0);
        GEN_EN = 1'b1;
        step();
        chk("run_entry_clk", CLK_OUT, 0);
        chk("run_entry_ack", FREQ_ACK, 0);
        k = 0;
        repeat (ncyc) begin
            step(); k++;
            chk("run_clk", CLK_OUT, mclk(f, k));
        end
        GEN_EN  = 1'b0;
        stopped = 0;
        budget  = int'(SYS / (2 * f)) + 4;
        repeat (budget) begin
            step(); k++;
            e = stopped ? 1'b0 : mclk(f, k);
            if (!e) stopped = 1;
            chk("stop_clk", CLK_OUT, e);
        end
    endtask

    initial begin
        longint k, f, rk, fk;
        int     rise, hi;
        bit     got, fell;
        logic   e;

        tbl[0] = '{12500000,   0, 1, 2};
        tbl[1] = '{12500001,   1, 0, 2};
        tbl[2] = '{1000000,    0, 1, 25};
        tbl[3] = '{64'hFFFFFFFF, 1, 0, 25};
        tbl[4] = '{0,          0, 1, 0};
        tbl[5] = '{3000000,    0, 1, 9};
        tbl[6] = '{12500002,   1, 0, 9};
        tbl[7] = '{7000000,    0, 1, 4};
        tbl[8] = '{250000,     0, 1, 100};

        // reset state
        RST_N = 1'b0; GEN_EN = 1'b0; FREQ_HZ = '0; FREQ_VLD = 1'b0;
        #1;
        chk("rst_clk", CLK_OUT, 0);
        chk("rst_busy", FREQ_BUSY, 0);
        chk("rst_ack", FREQ_ACK, 0);
        chk("rst_err", FREQ_ERR, 0);
        repeat (3) @(posedge CLK_50M);
        @(negedge CLK_50M) RST_N = 1'b1;
        step();

        // enable without a loaded frequency: must stay idle
        GEN_EN = 1'b1; hi = 0;
        repeat (20) begin step(); if (CLK_OUT) hi++; end
        chk("idle_no_freq_highs", hi, 0);
        GEN_EN = 1'b0;
        step();

        // request table: accept/reject plus first-rise latency
        for (int i = 0; i < 9; i++) begin
            FREQ_HZ = tbl[i].freq[31:0]; FREQ_VLD = 1'b1;
            step();
            FREQ_VLD = 1'b0;
            chk($sformatf("tbl%0d_err", i), FREQ_ERR, tbl[i].exp_err);
            chk($sformatf("tbl%0d_ack", i), FREQ_ACK, tbl[i].exp_ack);
            GEN_EN = 1'b1;
            step();
            rise = 0;
            for (int j = 1; j <= 200; j++) begin
                step();
                if (CLK_OUT) begin rise = j; break; end
            end
            chk($sformatf("tbl%0d_rise", i), rise, tbl[i].exp_rise);
            GEN_EN = 1'b0;
            got = 0;
            for (int j = 0; j < 300; j++) begin
                if (!CLK_OUT) begin got = 1; break; end
                step();
            end
            chk($sformatf("tbl%0d_stop_low", i), got, 1);
            step(); step();
        end

        // max rate for 1000 periods
        run_check(12500000, 4000);

        // random frequencies
        for (int r = 0; r < 6; r++) begin
            f = longint'($urandom_range(12500000, 250000));
            run_check(f, int'($urandom_range(400, 50)));
        end

        // glitch-free change 1 MHz -> 2 MHz requested mid high phase
        FREQ_HZ = 1000000; FREQ_VLD = 1'b1;
        step();
        FREQ_VLD = 1'b0;
        chk("chg_load_ack", FREQ_ACK, 1);
        GEN_EN = 1'b1;
        step();
        k = 0;
        repeat (35) begin step(); k++; chk("chg_pre_clk", CLK_OUT, mclk(1000000, k)); end
        FREQ_HZ = 2000000; FREQ_VLD = 1'b1;
        step(); k++;
        chk("chg_busy_rise", FREQ_BUSY, 1);
        chk("chg_accept_err", FREQ_ERR, 0);
        FREQ_HZ = 3000000;
        step(); k++;
        FREQ_VLD = 1'b0;
        chk("chg_busy_reject_err", FREQ_ERR, 1);
        chk("chg_busy_hold", FREQ_BUSY, 1);
        got = 0;
        for (int j = 0; j < 100; j++) begin
            step(); k++;
            chk("chg_pend_clk", CLK_OUT, mclk(1000000, k));
            if (FREQ_ACK) begin got = 1; break; end
        end
        chk("chg_ack_seen", got, 1);
        chk("chg_ack_at_fall_k", 32'(k), 50);
        chk("chg_busy_clear", FREQ_BUSY, 0);
        k = 0; rk = 0; fk = 0;
        repeat (100) begin
            step(); k++;
            chk("chg_new_clk", CLK_OUT, mclk(2000000, k));
            if (CLK_OUT && rk == 0) rk = k;
            if (!CLK_OUT && rk != 0 && fk == 0) fk = k;
        end
        chk("chg_new_low_len", 32'(rk), 13);
        chk("chg_new_high_len", 32'(fk - rk), 12);

        // load 0 while running: stop at the next fall with an ACK
        FREQ_HZ = 0; FREQ_VLD = 1'b1;
        step(); k++;
        FREQ_VLD = 1'b0;
        chk("zero_clk_req", CLK_OUT, mclk(2000000, k));
        got = 0; fell = 0;
        for (int j = 0; j < 60; j++) begin
            step(); k++;
            e = mclk(2000000, k);
            if (FREQ_ACK) begin
                got = 1;
                chk("zero_ack_at_fall", (mclk(2000000, k - 1) && !e && !fell), 1);
                chk("zero_ack_clk", CLK_OUT, 0);
                break;
            end
            chk("zero_pend_clk", CLK_OUT, e);
            if (mclk(2000000, k - 1) && !e) fell = 1;
        end
        chk("zero_ack_seen", got, 1);
        hi = 0;
        repeat (30) begin step(); if (CLK_OUT || FREQ_BUSY) hi++; end
        chk("zero_idle_after", hi, 0);

        // asynchronous reset while high with a request pending
        GEN_EN = 1'b0;
        step(); step();
        FREQ_HZ = 1000000; FREQ_VLD = 1'b1;
        step();
        FREQ_VLD = 1'b0;
        GEN_EN = 1'b1;
        got = 0;
        for (int j = 0; j < 100; j++) begin
            step();
            if (CLK_OUT) begin got = 1; break; end
        end
        chk("rst_mid_high_seen", got, 1);
        FREQ_HZ = 2000000; FREQ_VLD = 1'b1;
        step();
        FREQ_VLD = 1'b0;
        chk("rst_mid_busy", FREQ_BUSY, 1);
        #3 RST_N = 1'b0;
        #1;
        chk("rst_mid_clk", CLK_OUT, 0);
        chk("rst_mid_busy_clr", FREQ_BUSY, 0);
        chk("rst_mid_ack", FREQ_ACK, 0);
        chk("rst_mid_err", FREQ_ERR, 0);
        @(negedge CLK_50M) RST_N = 1'b1;
        hi = 0;
        repeat (60) begin step(); if (CLK_OUT || FREQ_ACK || FREQ_BUSY) hi++; end
        chk("rst_mid_stays_idle", hi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_gen_nco.md
# clk_gen_nco

Programmable square-wave clock generator clocked from the 50 MHz system clock. It is the transmit-side counterpart of the 1 s edge-counting clock detector: the detector measures an unknown clock in Hz, and this block synthesises a clock of a requested integer frequency in Hz. It uses a modulo-50,000,000 phase accumulator, so the long-term output frequency is exact. It drives test/loopback clocks into the design and accepts run-time frequency changes without glitches.

## Interface
Parameters:
- SYS_HZ, 50000000: system clock rate; accumulator modulus.
- FMAX_HZ, 12500000: highest accepted frequency, equal to SYS_HZ/4.

Ports:
- CLK_50M, in, 1: system clock. One clock domain only.
- RST_N, in, 1: reset, asynchronous assert, active-low.
- GEN_EN, in, 1: level. 1 runs the generator; 0 stops it cleanly.
- FREQ_HZ, in, 32: requested frequency in Hz; sampled when FREQ_VLD=1.
- FREQ_VLD, in, 1: one-cycle load request.
- FREQ_BUSY, out, 1: an accepted request is waiting to be applied.
- FREQ_ACK, out, 1: one-cycle pulse in the cycle a new frequency takes effect.
- FREQ_ERR, out, 1: one-cycle pulse when a request is rejected.
- CLK_OUT, out, 1: generated clock, registered, 50% duty on average.

## Operation
- Registers:
  - acc: 26 bits, range 0..SYS_HZ-1.
  - inc: 27 bits, equal to 2*freq.
  - freq_cur and freq_new: 32 bits.
  - state.
- Accumulator step, every RUN/PEND/STOP cycle:
  - sum = acc + inc, computed at 27 bits. The maximum is 74,999,999 < 2^27.
  - If sum >= SYS_HZ: acc <= sum - SYS_HZ and CLK_OUT toggles. Otherwise acc <= sum.
  - Because inc <= SYS_HZ/2, there is at most one wrap per cycle.
- Request handling (FREQ_VLD=1):
  - FREQ_HZ > FMAX_HZ: reject. FREQ_ERR pulses; no state change.
  - FREQ_BUSY=1: reject. FREQ_ERR pulses; the pending value is kept.
  - Otherwise accept:
    - In IDLE or STOP: freq_cur updates at once and FREQ_ACK pulses on the next cycle.
    - In RUN: freq_new <= FREQ_HZ and the FSM moves to PEND.
- FSM:
  - IDLE: CLK_OUT=0, acc=0. Goes to RUN when GEN_EN=1 and freq_cur!=0.
  - RUN: accumulates.
    - GEN_EN=0 goes to STOP.
    - An accepted request goes to PEND.
  - PEND: keeps running on the old frequency and FREQ_BUSY=1. In the cycle that CLK_OUT toggles 1->0:
    - freq_cur <= freq_new, acc <= 0, FREQ_ACK=1.
    - Next state is RUN. If freq_new=0 or GEN_EN=0, next state is IDLE instead.
    - GEN_EN=0 in PEND does not abort the change; the new value is still applied at that edge.
  - STOP: if CLK_OUT=0, go to IDLE next cycle. Otherwise keep accumulating until the 1->0 toggle, then IDLE. GEN_EN=1 during STOP returns to RUN with no phase reset.
- CLK_OUT never has a high phase shorter than its nominal high time. The only truncated phase is a low phase on entry from IDLE.
- Reset mid-operation clears everything immediately: CLK_OUT drops asynchronously and any pending request is lost.

## Timing
- Reset values: CLK_OUT=0, FREQ_BUSY=0, FREQ_ACK=0, FREQ_ERR=0, acc=0, freq_cur=0, state IDLE.
- FREQ_ERR is asserted in the cycle after the offending FREQ_VLD.
- FREQ_BUSY rises in the cycle after the accepting FREQ_VLD.
- FREQ_ACK and the new acc/inc take effect on the same edge where CLK_OUT falls. FREQ_BUSY clears on that edge.
- First CLK_OUT rise comes ceil(SYS_HZ/(2F)) cycles after the first RUN cycle.
- Half-period is floor or ceil of SYS_HZ/(2F) cycles. Over SYS_HZ cycles there are exactly 2F toggles when starting from acc=0.
- Examples:
  - F=12,500,000: period 4 cycles, high 2, low 2.
  - F=1: high 25,000,000 cycles, low 25,000,000 cycles.
- Worst-case request latency is one old-frequency period (1 s at F=1).

## Test plan
- Reset: assert RST_N=0 mid-run with CLK_OUT=1. Required: CLK_OUT=0 without waiting for a clock edge, all flags 0, and after release the block stays in IDLE until a load.
- Max rate: load 12,500,000 in IDLE, then GEN_EN=1. Required: ACK one cycle after load, first rise 2 cycles after RUN entry, then period exactly 4 cycles with high 2 / low 2 for 1000 periods.
- Exactness: load 3, run 50,000,000 cycles. Required: exactly 6 toggles (3 rises). Looped into the clock detector, it reports 3 after its second window.
- Rejects: FREQ_HZ=12,500,001 gives an FREQ_ERR pulse and unchanged output. A second FREQ_VLD while FREQ_BUSY=1 gives FREQ_ERR and the first value is still applied.
- Glitch-free change: switch 1,000,000 to 2,000,000 while running, with the request arriving mid high phase.
  - Required: the old high phase completes its full 25 cycles.
  - Then ACK coincides with the fall.
  - Afterwards the phases are 12/13-cycle high/low halves.
- Stop/zero: GEN_EN=0 while CLK_OUT=1 gives a full high phase, then IDLE with CLK_OUT=0. Loading 0 while running stops at the next fall with an ACK.
